// File: rtl/mult_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module   : mult_ctrl_param
// Brief    : Sequencing FSM for a WIDTH-bit shift-add multiplier datapath.
//            Generates load/clear, add/subtract and shift strobes, tracks the
//            iteration count, and supports signed mode and a zero-skip path.
// Revision : 1.0 - initial release
// ============================================================================
module mult_ctrl_param #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    input  logic          ClearA_LoadB,
    input  logic          m,
    input  logic          signed_mode,
    input  logic          skip_zero,
    output logic          clr_ld,
    output logic          clearA,
    output logic          add,
    output logic          sub,
    output logic          shift,
    output logic          shift_arith,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] iter
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_CLEAR = 3'd2;
    localparam logic [2:0] S_ADD   = 3'd3;
    localparam logic [2:0] S_SHIFT = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);
    localparam logic [CW-1:0] c_one  = CW'(1);

    logic [2:0]    r_state;
    logic [2:0]    w_next;
    logic [CW-1:0] r_iter;
    logic [CW-1:0] w_iter_next;
    logic          r_signed_l;
    logic          r_skip_l;
    logic          w_last;

    assign w_last = (r_iter == c_last);
    assign iter   = r_iter;

    // State, iteration counter and per-multiply mode latches
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_iter     <= '0;
            r_signed_l <= 1'b0;
            r_skip_l   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_iter  <= w_iter_next;
            // Modes are frozen at the start of a multiply so mid-run switch
            // changes cannot corrupt the sequence
            if (r_state == S_CLEAR) begin
                r_signed_l <= signed_mode;
                r_skip_l   <= skip_zero;
            end
        end
    end

    // Next-state, counter update and strobe decode
    always_comb begin
        w_next      = r_state;
        w_iter_next = r_iter;
        clr_ld      = 1'b0;
        clearA      = 1'b0;
        add         = 1'b0;
        sub         = 1'b0;
        shift       = 1'b0;
        shift_arith = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ClearA_LoadB) begin
                    w_next = S_LOAD;
                end else if (run) begin
                    w_next = S_CLEAR;
                end
            end
            S_LOAD: begin
                clr_ld = 1'b1;
                w_next = S_IDLE;
            end
            S_CLEAR: begin
                clearA      = 1'b1;
                busy        = 1'b1;
                w_iter_next = '0;
                w_next      = S_ADD;
            end
            S_ADD: begin
                busy        = 1'b1;
                shift_arith = r_signed_l;
                if (r_skip_l && !m) begin
                    // Nothing to accumulate: fuse the shift into this cycle
                    shift       = 1'b1;
                    w_iter_next = r_iter + c_one;
                    w_next      = w_last ? S_DONE : S_ADD;
                end else begin
                    // Sign bit of a two's-complement multiplier has negative weight
                    add    = m & ~(r_signed_l & w_last);
                    sub    = m & r_signed_l & w_last;
                    w_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                busy        = 1'b1;
                shift       = 1'b1;
                shift_arith = r_signed_l;
                w_iter_next = r_iter + c_one;
                w_next      = w_last ? S_DONE : S_ADD;
            end
            S_DONE: begin
                done   = 1'b1;
                // Level-sensitive run: wait for release before re-arming
                w_next = run ? S_DONE : S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mult_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_ctrl_param
// Brief    : Scoreboard bench for mult_ctrl_param. A stimulus process issues
//            multiplies and queues the expected summary of each; a monitor
//            collects the strobes of each multiply and checks at done.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_ctrl_param;

    localparam int W = 8;

    typedef struct {
        int         lat;
        logic [7:0] am;
        logic [7:0] sm;
        logic       sa;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset, run, ClearA_LoadB, m, signed_mode, skip_zero;
    logic       clr_ld, clearA, add, sub, shift, shift_arith, busy, done;
    logic [3:0] iter;

    logic       run4, m4, signed4, skip4, clrldb4;
    logic       clr_ld4, clearA4, add4, sub4, shift4, shift_arith4, busy4, done4;
    logic [2:0] iter4;

    int         checks   = 0;
    int         failures = 0;
    exp_t       exp_q[$];

    logic [7:0] mult_val = 8'h00;
    logic [3:0] sh_cnt   = 4'd0;

    always #5 clk = ~clk;

    mult_ctrl_param #(.WIDTH(W)) u_dut (
        .clk(clk), .reset(reset), .run(run), .ClearA_LoadB(ClearA_LoadB), .m(m),
        .signed_mode(signed_mode), .skip_zero(skip_zero), .clr_ld(clr_ld),
        .clearA(clearA), .add(add), .sub(sub), .shift(shift),
        .shift_arith(shift_arith), .busy(busy), .done(done), .iter(iter)
    );

    mult_ctrl_param #(.WIDTH(4)) u_dut4 (
        .clk(clk), .reset(reset), .run(run4), .ClearA_LoadB(clrldb4), .m(m4),
        .signed_mode(signed4), .skip_zero(skip4), .clr_ld(clr_ld4),
        .clearA(clearA4), .add(add4), .sub(sub4), .shift(shift4),
        .shift_arith(shift_arith4), .busy(busy4), .done(done4), .iter(iter4)
    );

    // Model of multiplier register B: its LSB is the bit consumed so far
    always @(posedge clk) begin
        if (clearA) sh_cnt <= 4'd0;
        else if (shift) sh_cnt <= sh_cnt + 4'd1;
    end
    assign m = (sh_cnt < 4'd8) ? mult_val[sh_cnt[2:0]] : 1'b0;

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, expv);
        end
    endtask

    // Monitor: accumulate strobes from clearA to done, then score
    int         cyc, n_sh;
    logic [7:0] am, sm;
    logic       sa_and, sa_or, bad, active = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            active = 1'b0;
        end else if (clearA) begin
            active = 1'b1; cyc = 0; n_sh = 0; am = '0; sm = '0;
            sa_and = 1'b1; sa_or = 1'b0; bad = !busy;
        end else if (active) begin
            cyc++;
            if (int'(add) + int'(sub) + int'(shift) > 1) bad = 1'b1;
            if (done) begin
                active = 1'b0;
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("latency", cyc, e.lat);
                    chk("shift_count", n_sh, W);
                    chk("add_iters", int'(am), int'(e.am));
                    chk("sub_iters", int'(sm), int'(e.sm));
                    chk("shift_arith_all", int'(sa_and), int'(e.sa));
                    chk("shift_arith_any", int'(sa_or), int'(e.sa));
                    chk("iter_at_done", int'(iter), W);
                    chk("busy_excl", int'(bad), 0);
                    chk("busy_at_done", int'(busy), 0);
                end
            end else begin
                if (!busy) bad = 1'b1;
                if (add) am[iter[2:0]] = 1'b1;
                if (sub) sm[iter[2:0]] = 1'b1;
                if (shift) begin
                    n_sh++;
                    sa_and &= shift_arith;
                    sa_or  |= shift_arith;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one multiply; optionally via a simultaneous load request, a
    // mid-run signed_mode flip, and run held through DONE
    task automatic do_mul(input logic [7:0] mv, input logic sg, input logic sk,
                          input logic with_load, input logic flip, input logic hold);
        exp_t e;
        int   zeros;
        zeros = 0;
        for (int i = 0; i < W; i++) if (!mv[i]) zeros++;
        e.lat = 2 * W + 1 - (sk ? zeros : 0);
        e.am  = sg ? {1'b0, mv[6:0]} : mv;
        e.sm  = sg ? {mv[7], 7'b0} : 8'h00;
        e.sa  = sg;
        exp_q.push_back(e);
        mult_val = mv; signed_mode = sg; skip_zero = sk; run = 1'b1;
        if (with_load) begin
            ClearA_LoadB = 1'b1;
            tick();
            ClearA_LoadB = 1'b0;
            chk("load_strobe", int'(clr_ld), 1);
            chk("load_no_clear", int'(clearA), 0);
            tick();
            chk("load_back_idle", int'({clr_ld, clearA, busy}), 0);
            tick();
            chk("load_then_clear", int'(clearA), 1);
        end else begin
            tick();
        end
        tick();
        if (flip) signed_mode = ~sg;
        for (int k = 0; k < 40 && !done; k++) tick();
        chk("done_seen", int'(done), 1);
        if (hold) begin
            for (int k = 0; k < 5; k++) begin
                tick();
                chk("held_no_restart", int'({done, busy, clearA}), 3'b100);
            end
        end
        run = 1'b0;
        tick();
        tick();
        chk("idle_after_run_low", int'({done, busy}), 0);
    endtask

    initial begin
        int adds4, subs4, shifts4, sa4, first_done4;
        reset = 1'b1; run = 1'b0; ClearA_LoadB = 1'b0; signed_mode = 1'b0; skip_zero = 1'b0;
        run4 = 1'b0; m4 = 1'b1; signed4 = 1'b0; skip4 = 1'b0; clrldb4 = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk("reset_outputs", int'({clr_ld, clearA, add, sub, shift, shift_arith, busy, done}), 0);
        chk("reset_iter", int'(iter), 0);

        do_mul(8'h81, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);   // signed, add at 0, sub at 7
        do_mul(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);   // skip, all fused shifts
        do_mul(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);   // unsigned: add on last bit
        do_mul(8'h5A, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);   // load+run together, run held
        do_mul(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);   // signed_mode flipped mid-run

        // Reset during SHIFT at iteration 3
        mult_val = 8'h96; signed_mode = 1'b0; skip_zero = 1'b0; run = 1'b1;
        for (int k = 0; k < 40 && !(shift && iter == 4'd3); k++) tick();
        chk("reached_shift3", int'(shift && iter == 4'd3), 1);
        reset = 1'b1; run = 1'b0;
        tick();
        reset = 1'b0;
        chk("midrun_reset_iter", int'(iter), 0);
        chk("midrun_reset_out", int'({clr_ld, clearA, add, sub, shift, shift_arith, busy, done}), 0);
        tick();
        do_mul(8'h96, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);   // full multiply after reset

        for (int n = 0; n < 10; n++)
            do_mul(8'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0, 1'($urandom));

        // WIDTH=4 instance, unsigned, m always 1
        adds4 = 0; subs4 = 0; shifts4 = 0; sa4 = 0; first_done4 = 0;
        run4 = 1'b1;
        for (int k = 1; k <= 20 && first_done4 == 0; k++) begin
            tick();
            if (add4) adds4++;
            if (sub4) subs4++;
            if (shift4) begin shifts4++; if (shift_arith4) sa4++; end
            if (done4) first_done4 = k;
        end
        run4 = 1'b0;
        chk("w4_adds", adds4, 4);
        chk("w4_subs", subs4, 0);
        chk("w4_shifts", shifts4, 4);
        chk("w4_shift_arith", sa4, 0);
        chk("w4_done_cycle", first_done4, 10);
        chk("w4_iter_done", int'(iter4), 4);

        tick();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mult_ctrl_param.md
Name: mult_ctrl_param

Overview:
- Parametrised sequencing FSM for the shift-add multiplier datapath. Successor to the fixed 8-bit multiplier control unit.
- Drives register load/clear, add/subtract and shift strobes for a WIDTH-bit operand. Holds its own iteration counter.
- New over the previous generation: run-time signed/unsigned mode, an optional zero-skip fast path that fuses add and shift when m=0, and busy/done handshake outputs.
- Sits between the switch/button debouncers and the register unit / adder-subtractor.

Parameters:
- WIDTH, 8, operand width = number of iterations; legal range 2..32.
- CW, $clog2(WIDTH+1), iteration counter width; derived, not overridden.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high; returns block to IDLE
- run  in  1  level start request; one multiply per high period
- ClearA_LoadB  in  1  request to clear A and load B from switches
- m  in  1  current LSB of multiplier register B
- signed_mode  in  1  1 = two's-complement (last-iteration subtract, arithmetic shift); 0 = unsigned
- skip_zero  in  1  1 = fuse shift into add cycle when m=0
- clr_ld  out  1  clear A / load B strobe
- clearA  out  1  clear A and X before a multiply
- add  out  1  A <= A + S this cycle
- sub  out  1  A <= A - S this cycle
- shift  out  1  shift X:A:B right one bit
- shift_arith  out  1  1 = shift in X (sign); 0 = shift in 0; equals latched signed_mode
- busy  out  1  multiply in progress
- done  out  1  multiply finished; held until run low
- iter  out  CW  current iteration index

Behaviour:
- States: IDLE, LOAD, CLEAR, ADD, SHIFT, DONE.
- Outputs are Moore-decoded from the state register, except add, sub and shift in ADD, which also depend on m.
- Reset (any state, including mid-multiply): state=IDLE, iter=0, latched signed_l=0 and skip_l=0. All strobes, busy and done are 0 the cycle after reset is sampled.
- IDLE, all outputs 0:
  - ClearA_LoadB=1 -> LOAD. Takes priority over run.
  - else run=1 -> CLEAR.
  - else stay in IDLE.
- LOAD: clr_ld=1 for exactly one cycle -> IDLE. If run is still high, a multiply starts from IDLE next.
- CLEAR:
  - clearA=1, busy=1.
  - iter<=0; signed_l<=signed_mode; skip_l<=skip_zero.
  - -> ADD.
- ADD, busy=1. Let last = (iter==WIDTH-1).
  - skip_l=1 and m=0: shift=1, add=0, sub=0; iter<=iter+1. Next state is DONE if last, else ADD.
  - otherwise: add = m & ~(signed_l & last); sub = m & signed_l & last; shift=0 -> SHIFT.
- SHIFT: shift=1, busy=1, iter<=iter+1. Next state is DONE if last, else ADD.
- DONE:
  - done=1, busy=0, iter holds WIDTH.
  - run=1 -> stay in DONE (no restart); run=0 -> IDLE.
- Outputs while busy:
  - shift_arith = signed_l in every state.
  - add, sub and shift are mutually exclusive.
  - Exactly WIDTH shift strobes occur per multiply.
- Ignored while busy:
  - ClearA_LoadB and run.
  - Changes to signed_mode and skip_zero after CLEAR.
- Latency, counted from the edge sampling run=1 in IDLE:
  - skip_l=0: done first high in cycle 2*WIDTH+2.
  - skip_l=1: between WIDTH+2 (all m=0) and 2*WIDTH+2 (all m=1).
- Counter never wraps: iter saturates at WIDTH in DONE; it is reset only in CLEAR or by reset.
- Unsigned mode: the last iteration with m=1 asserts add, never sub.

Test Plan:
- WIDTH=8, signed, skip=0, run pulse, m pattern of 0x81 (m=1 at iter 0 and 7) -> add at iter 0, sub at iter 7, 8 shifts, done first high at cycle 18, busy high cycles 1..17.
- WIDTH=8, skip=1, m always 0 -> no add/sub, 8 fused shift cycles, done at cycle 10, iter=8.
- WIDTH=4, unsigned, m always 1 -> 4 adds, 0 subs, shift_arith=0, done at cycle 10.
- ClearA_LoadB=1 and run=1 in the same IDLE cycle -> clr_ld for one cycle, then IDLE, then CLEAR on the next cycle; run held high through DONE -> no second multiply until run drops and rises again.
- reset asserted during SHIFT at iter=3 -> next cycle IDLE, iter=0, all strobes 0; a subsequent run performs a full 2*WIDTH+2 cycle multiply.
- signed_mode toggled mid-multiply (0->1 after CLEAR) -> shift_arith stays 0 and the final iteration asserts add, not sub.
